// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : mem_ctrl_pkg                                          |
// | Purpose  : Shared access-width codes, FSM state encoding and     |
// |            small decode helpers for the memory controller.       |
// | Contents : RW_* width/sign codes, state_t, size_t, op_size(),    |
// |            is_misaligned()                                       |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
package mem_ctrl_pkg;

  // Width/sign codes carried on req_op
  localparam logic [2:0] RW_SB = 3'b000;
  localparam logic [2:0] RW_SH = 3'b001;
  localparam logic [2:0] RW_SW = 3'b010;
  localparam logic [2:0] RW_UB = 3'b100;
  localparam logic [2:0] RW_UH = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_MERGE = 3'd2,
    ST_WR    = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  // Undefined codes fall through to a full-word access.
  function automatic size_t op_size(input logic [2:0] op);
    case (op)
      RW_SB, RW_UB: return SZ_BYTE;
      RW_SH, RW_UH: return SZ_HALF;
      default:      return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] lo);
    case (op_size(op))
      SZ_HALF: return lo[0];
      SZ_WORD: return (lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lane_align.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : lane_align                                            |
// | Purpose  : Combinational byte-lane logic: merges sub-word store  |
// |            data into a RAM word and extracts/extends load data.  |
// | Ports    : op          - RW_* width/sign code                    |
// |            byte_off    - byte address bits [1:0]                 |
// |            store_data  - right-aligned store data (low 16 bits)  |
// |            ram_word    - word read from RAM                      |
// |            merged_word - ram_word with addressed lane replaced   |
// |            load_data   - extended load result                    |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module lane_align
  import mem_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  byte_off,
  input  logic [15:0] store_data,
  input  logic [31:0] ram_word,
  output logic [31:0] merged_word,
  output logic [31:0] load_data
);

  logic [4:0]  bit_off;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign bit_off  = {byte_off, 3'b000};
  assign sel_byte = ram_word[bit_off +: 8];
  assign sel_half = byte_off[1] ? ram_word[31:16] : ram_word[15:0];

  always_comb begin
    load_data = ram_word;
    case (op)
      RW_SB:   load_data = {{24{sel_byte[7]}}, sel_byte};
      RW_UB:   load_data = {24'h000000, sel_byte};
      RW_SH:   load_data = {{16{sel_half[15]}}, sel_half};
      RW_UH:   load_data = {16'h0000, sel_half};
      default: load_data = ram_word;
    endcase
  end

  always_comb begin
    merged_word = ram_word;
    case (op_size(op))
      SZ_BYTE: merged_word[bit_off +: 8] = store_data[7:0];
      SZ_HALF: begin
        if (byte_off[1]) merged_word[31:16] = store_data;
        else             merged_word[15:0]  = store_data;
      end
      default: merged_word = ram_word;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : mem_ctrl                                              |
// | Purpose  : CPU-to-RAM load/store controller with byte/half/word  |
// |            accesses, read-modify-write for sub-word stores and   |
// |            misalignment detection.                               |
// | Ports    : clk, rst (async, active-high)                         |
// |            req_*  - CPU request (valid/ready handshake)          |
// |            rsp_*  - one-cycle response pulse, data, error        |
// |            ram_*  - single-port synchronous RAM interface        |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  state_t            state, state_nxt;
  logic [2:0]        op_q;
  logic              we_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic              accept;
  logic              req_mis;
  logic [31:0]       merged_word;
  logic [31:0]       load_data;

  // Byte-address bits above the RAM window are intentionally ignored.
  logic              unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  assign req_mis = is_misaligned(req_op, req_addr[1:0]);
  assign accept  = (state == ST_IDLE) && req_valid;

  lane_align u_lane_align (
    .op          (op_q),
    .byte_off    (addr_q[1:0]),
    .store_data  (wdata_q[15:0]),
    .ram_word    (ram_rdata),
    .merged_word (merged_word),
    .load_data   (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state and RAM strobes. RAM strobes depend only on state so an
  // asynchronous reset drops ram_we in the same cycle it is asserted.
  always_comb begin
    state_nxt = state;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_wdata = 32'h0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_mis)                                     state_nxt = ST_RESP;
          else if (req_we && op_size(req_op) == SZ_WORD)   state_nxt = ST_WR;
          else                                             state_nxt = ST_RD;
        end
      end
      ST_RD: begin
        ram_en    = 1'b1;
        state_nxt = ST_MERGE;
      end
      ST_MERGE: begin
        // Sub-word store: write back the read word with one lane patched.
        if (we_q) begin
          ram_en    = 1'b1;
          ram_we    = 1'b1;
          ram_wdata = merged_word;
        end
        state_nxt = ST_RESP;
      end
      ST_WR: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_wdata = wdata_q;
        state_nxt = ST_RESP;
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= RW_SB;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= req_op;
        we_q    <= req_we;
        addr_q  <= req_addr[ADDR_W+1:0];
        wdata_q <= req_wdata;
        err_q   <= req_mis;
        if (req_mis) rdata_q <= 32'h0;
      end
      // Response data is settled on the edge entering RESP and then held.
      if (state == ST_MERGE) rdata_q <= we_q ? 32'h0 : load_data;
      if (state == ST_WR)    rdata_q <= 32'h0;
    end
  end

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign rsp_err   = err_q && (state == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign ram_addr  = addr_q[ADDR_W+1:2];

endmodule
`default_nettype wire
